uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/uart_frame_parser_byte_rx.sv | 94 +++++++++
 rtl/uart_frame_parser.sv | 144 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser and its byte receiver.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHK     = 2'd2,
        TAILCHK = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TAIL    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CHKSUM  = 2'd3;

    localparam logic [7:0] HEAD_DEFAULT = 8'hDD;
    localparam logic [7:0] TAIL_DEFAULT = 8'hEE;

endpackage

// File: rtl/uart_frame_parser_byte_rx.sv
// 8N1 UART byte receiver: double-flop synchroniser, mid-bit sampling, one-cycle byte_done strobe.
module uart_byte_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_done
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;
    logic               rx_q1, rx_s;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_q1   <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            rx_q1   <= rx;
            rx_s    <= rx_q1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Start bit is re-checked at mid-bit so short glitches fall back to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte   = data_q;
    assign byte_done = done_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Framed UART receiver: HEAD, fixed payload, optional sum checksum (UART_FRAME_CHKSUM_EN), TAIL,
// with inter-byte timeout; reports good frames on frame_valid and aborts on frame_err/err_code.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEAD          = HEAD_DEFAULT,
    parameter logic [7:0]  TAIL          = TAIL_DEFAULT,
    parameter int unsigned PAYLOAD_BYTES = 30,
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       uart_rx,
    output logic [PAYLOAD_BYTES*8-1:0] frame_data,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code
);

    localparam int unsigned PW        = PAYLOAD_BYTES * 8;
    localparam int unsigned IDX_W     = $clog2(PAYLOAD_BYTES + 1);
    localparam int unsigned TO_CYCLES = 32'(64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(BAUD));
    localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

    logic [7:0]      rx_byte;
    logic            byte_done;

    frame_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]      sum_q, sum_d;
    logic [PW-1:0]   shadow_q, shadow_d;
    logic [PW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [TO_W-1:0] to_q, to_d;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_byte_rx (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .rx        (uart_rx),
        .rx_byte   (rx_byte),
        .byte_done (byte_done)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sum_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            code_q   <= code_d;
            to_q     <= to_d;
        end
    end

    // A byte arriving in the timeout cycle wins, since it also clears the counter.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        to_d     = (state_q == IDLE || byte_done) ? '0 : to_q + TO_W'(1);

        if (state_q != IDLE && !byte_done && to_q == TO_W'(TO_CYCLES - 1)) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = IDLE;
            to_d    = '0;
        end else if (byte_done) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte == HEAD) begin
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    shadow_d = (shadow_q << 8) | PW'(rx_byte);
                    sum_d    = sum_q + rx_byte;
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
`ifdef UART_FRAME_CHKSUM_EN
                        state_d = CHK;
`else
                        state_d = TAILCHK;
`endif
                    end
                end
`ifdef UART_FRAME_CHKSUM_EN
                CHK: begin
                    if (rx_byte == sum_q) begin
                        state_d = TAILCHK;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHKSUM;
                        state_d = IDLE;
                    end
                end
`endif
                TAILCHK: begin
                    state_d = IDLE;
                    if (rx_byte == TAIL) begin
                        data_d  = shadow_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_TAIL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a 4-byte payload; checksum cases run when UART_FRAME_CHKSUM_EN is defined.
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BIT      = CLK_FREQ / BAUD;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    uart_frame_parser #(
        .HEAD          (8'hDD),
        .TAIL          (8'hEE),
        .PAYLOAD_BYTES (4),
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .TIMEOUT_BYTES (4)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .uart_rx     (uart_rx),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (frame_valid && frame_err) both_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge Clk);
        end
        uart_rx = 1'b1;
        repeat (BIT) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] tail);
        logic [7:0] s;
        s = pl[31:24] + pl[23:16] + pl[15:8] + pl[7:0];
        send_byte(8'hDD);
        for (int i = 3; i >= 0; i--) send_byte(pl[i*8 +: 8]);
`ifdef UART_FRAME_CHKSUM_EN
        send_byte(s);
`else
        if (s == 8'h00) uart_rx = 1'b1;
`endif
        send_byte(tail);
        repeat (20) @(negedge Clk);
    endtask

    task automatic check_counts(input string name, input int v0, input int e0, input int dv, input int de);
        checks++;
        if (valid_cnt - v0 !== dv) begin
            errors++;
            $display("FAIL %s valid pulses got %0d want %0d", name, valid_cnt - v0, dv);
        end
        checks++;
        if (err_cnt - e0 !== de) begin
            errors++;
            $display("FAIL %s err pulses got %0d want %0d", name, err_cnt - e0, de);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (5) @(negedge Clk);
        checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", frame_data); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", err_code); end
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_good_frame();
        int v0 = valid_cnt, e0 = err_cnt;
        send_frame(32'h11223344, 8'hEE);
        check_counts("good_frame", v0, e0, 1, 0);
        checks++; if (frame_data !== 32'h11223344) begin errors++; $display("FAIL good_frame_data got %h want 11223344", frame_data); end
    endtask

    task automatic test_bad_tail();
        int v0 = valid_cnt, e0 = err_cnt;
        send_frame(32'h11223344, 8'h55);
        check_counts("bad_tail", v0, e0, 0, 1);
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL bad_tail_code got %0d want 1", err_code); end
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(32'hAABBCCDD, 8'hEE);
        check_counts("after_bad_tail", v0, e0, 1, 0);
        checks++; if (frame_data !== 32'hAABBCCDD) begin errors++; $display("FAIL after_bad_tail_data got %h want aabbccdd", frame_data); end
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL bad_tail_code_hold got %0d want 1", err_code); end
    endtask

    task automatic test_timeout();
        int v0 = valid_cnt, e0 = err_cnt;
        int cyc = 0;
        bit seen = 1'b0;
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (20) @(negedge Clk);
        check_counts("noise_ignored", v0, e0, 0, 0);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL noise_state got %0d want IDLE", dut.state_q); end
        send_byte(8'hDD);
        send_byte(8'h11);
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge Clk);
            cyc++;
            if (frame_err) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc < 380 || cyc > 410) begin
            errors++;
            $display("FAIL timeout_delay got seen=%0b cycles=%0d want about 400", seen, cyc);
        end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL timeout_code got %0d want 2", err_code); end
        checks++; if (frame_data !== 32'hAABBCCDD) begin errors++; $display("FAIL timeout_data got %h want aabbccdd", frame_data); end
        repeat (5) @(negedge Clk);
        check_counts("timeout", v0, e0, 0, 1);
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        send_byte(8'hDD);
        send_byte(8'h11);
        send_byte(8'h22);
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL mid_reset_data got %h want 00000000", frame_data); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL mid_reset_code got %0d want 0", err_code); end
        checks++; if ({frame_valid, frame_err} !== 2'b00) begin errors++; $display("FAIL mid_reset_pulses got %b want 00", {frame_valid, frame_err}); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_reset_state got %0d want IDLE", dut.state_q); end
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hEE);
        repeat (600) @(negedge Clk);
        check_counts("trailing_bytes", v0, e0, 0, 0);
        send_frame(32'h01DD03EE, 8'hEE);
        check_counts("recover", v0, e0, 1, 0);
        checks++; if (frame_data !== 32'h01DD03EE) begin errors++; $display("FAIL recover_data got %h want 01dd03ee", frame_data); end
    endtask

`ifdef UART_FRAME_CHKSUM_EN
    task automatic test_checksum();
        int v0 = valid_cnt, e0 = err_cnt;
        send_byte(8'hDD); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04); send_byte(8'h0A); send_byte(8'hEE);
        repeat (20) @(negedge Clk);
        check_counts("chk_good", v0, e0, 1, 0);
        checks++; if (frame_data !== 32'h01020304) begin errors++; $display("FAIL chk_good_data got %h want 01020304", frame_data); end
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'hDD); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04); send_byte(8'h0B); send_byte(8'hEE);
        repeat (20) @(negedge Clk);
        check_counts("chk_bad", v0, e0, 0, 1);
        checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL chk_bad_code got %0d want 3", err_code); end
        checks++; if (frame_data !== 32'h01020304) begin errors++; $display("FAIL chk_bad_data got %h want 01020304", frame_data); end
    endtask
`endif

    task automatic test_exclusive();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL exclusive_pulses got %0d want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_tail();
        test_timeout();
        test_reset_mid();
`ifdef UART_FRAME_CHKSUM_EN
        test_checksum();
`endif
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
